// File: rtl/traffic_pkg.sv
// Shared definitions for the highway/country-road traffic light controller:
// light encodings and the country sensor conditioner state type.
package traffic_pkg;

   localparam logic [1:0] RED    = 2'b00;
   localparam logic [1:0] YELLOW = 2'b01;
   localparam logic [1:0] GREEN  = 2'b10;

   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      PENDING = 2'b01,
      EXTEND  = 2'b10,
      RELEASE = 2'b11
   } cond_state_e;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer for the raw loop detector followed by a debouncer:
// det_o follows the synchronized input only after DEB_CYCLES consecutive differing samples.
module sync_debounce #(
   parameter int DEB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic loop_raw_i,
   output logic det_o
);

   localparam int DC_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

   logic            sync1_q;
   logic            s_q;
   logic            det_q, det_d;
   logic [DC_W-1:0] cnt_q, cnt_d;

   // The counter holds the number of differing samples already seen, so the
   // DEB_CYCLES-th one flips det directly.
   always_comb begin
      det_d = det_q;
      cnt_d = '0;
      if (s_q != det_q) begin
         if (cnt_q == DC_W'(DEB_CYCLES - 1)) begin
            det_d = s_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         det_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= loop_raw_i;
         s_q     <= sync1_q;
         det_q   <= det_d;
         cnt_q   <= cnt_d;
      end
   end

   assign det_o = det_q;

endmodule

// File: rtl/country_sensor_conditioner.sv
// Country-road loop conditioner: latches a vehicle request until served, extends green
// while traffic keeps arriving (capped), counts arrivals. STUCK_FAULT_EN adds a stuck-loop fault.
//
// state   | meaning
// IDLE    | no vehicle waiting, car_req low
// PENDING | vehicle waiting for country green, car_req high
// EXTEND  | country green, holding request while traffic keeps arriving
// RELEASE | request dropped, waiting for country light to leave green
module country_sensor_conditioner
   import traffic_pkg::*;
#(
   parameter int DEB_CYCLES   = 4,
   parameter int GAP_CYCLES   = 8,
   parameter int MAX_GREEN    = 32,
   parameter int STUCK_CYCLES = 1024,
   parameter int CNT_W        = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             loop_raw_i,
   input  logic [1:0]       country_light_i,
   output logic             car_req_o,
   output logic [CNT_W-1:0] car_count_o,
   output logic             fault_o
);

   localparam int GAP_W = $clog2(GAP_CYCLES + 1);
   localparam int GRN_W = (MAX_GREEN > 1) ? $clog2(MAX_GREEN) : 1;

   logic det;
   logic det_eff;
   logic fault_q;

   sync_debounce #(
      .DEB_CYCLES (DEB_CYCLES)
   ) u_sync_debounce (
      .clk        (clk),
      .rst        (rst),
      .loop_raw_i (loop_raw_i),
      .det_o      (det)
   );

`ifdef STUCK_FAULT_EN
   localparam int STK_W = (STUCK_CYCLES > 1) ? $clog2(STUCK_CYCLES) : 1;

   logic [STK_W-1:0] stuck_q, stuck_d;
   logic             fault_d;

   always_comb begin
      stuck_d = '0;
      fault_d = fault_q;
      if (det) begin
         stuck_d = stuck_q;
         if (stuck_q == STK_W'(STUCK_CYCLES - 1)) begin
            fault_d = 1'b1;
         end else begin
            stuck_d = stuck_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stuck_q <= '0;
         fault_q <= 1'b0;
      end else begin
         stuck_q <= stuck_d;
         fault_q <= fault_d;
      end
   end

   // A stuck loop masks detection so an open request drains through gap expiry.
   assign det_eff = det & ~fault_q;
`else
   logic unused_stuck;
   assign unused_stuck = (STUCK_CYCLES != 0);
   assign fault_q      = 1'b0;
   assign det_eff      = det;
`endif

   logic             det_prev_q;
   logic             arrival;
   logic [CNT_W-1:0] count_q, count_d;

   assign arrival = det_eff & ~det_prev_q;

   always_comb begin
      count_d = count_q;
      if (arrival && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   cond_state_e      state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [GRN_W-1:0] green_q, green_d;
   logic             arr_rel_q, arr_rel_d;
   logic             car_req_q, car_req_d;
   logic             is_green;

   assign is_green = (country_light_i == GREEN);

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      green_d   = green_q;
      arr_rel_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (det_eff) state_d = PENDING;
         end
         PENDING: begin
            if (is_green) begin
               state_d = EXTEND;
               gap_d   = GAP_W'(GAP_CYCLES);
               green_d = '0;
            end
         end
         EXTEND: begin
            green_d = green_q + 1'b1;
            if (det_eff) begin
               gap_d = GAP_W'(GAP_CYCLES);
            end else if (gap_q != '0) begin
               gap_d = gap_q - 1'b1;
            end
            // Cap wins over any reload: the state leaves regardless of det.
            if ((green_q == GRN_W'(MAX_GREEN - 1)) || !is_green ||
                ((gap_q == '0) && !det_eff)) begin
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            arr_rel_d = arr_rel_q | arrival;
            if (!is_green) begin
               state_d   = (det_eff || arr_rel_q || arrival) ? PENDING : IDLE;
               arr_rel_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
      car_req_d = (state_d == PENDING) || (state_d == EXTEND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gap_q      <= '0;
         green_q    <= '0;
         arr_rel_q  <= 1'b0;
         car_req_q  <= 1'b0;
         det_prev_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         gap_q      <= gap_d;
         green_q    <= green_d;
         arr_rel_q  <= arr_rel_d;
         car_req_q  <= car_req_d;
         det_prev_q <= det_eff;
         count_q    <= count_d;
      end
   end

   assign car_req_o   = car_req_q;
   assign car_count_o = count_q;
   assign fault_o     = fault_q;

endmodule

// File: doc/country_sensor_conditioner.md
Name: country_sensor_conditioner

Overview:
- Upstream stage of the highway/country-road traffic light controller.
- Turns the raw, asynchronous, bouncy country-road loop-detector signal into the clean vehicle-request level `car_req`, which drives the controller's `x` input.
- Watches the controller's country-road light. It latches a request until the road is served, extends green while traffic keeps arriving, and caps the extension so the highway is not starved.
- Also counts vehicle arrivals.

Parameters:
- DEB_CYCLES, 4: consecutive stable synchronized samples required before the debounced level `det` changes.
- GAP_CYCLES, 8: green-extension gap; `car_req` drops after this many cycles with no vehicle present.
- MAX_GREEN, 32: maximum cycles `car_req` is held high once the country light is green.
- STUCK_CYCLES, 1024: continuous `det`=1 cycles before the loop is declared stuck (only with the optional feature).
- CNT_W, 8: width of the arrival counter.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, synchronous, active-high.
- loop_raw, input, 1: raw loop detector, asynchronous to clk, high = vehicle present.
- country_light, input, 2: current country-road light from the controller (red=00, yellow=01, green=10).
- car_req, output, 1: registered vehicle request to the controller.
- car_count, output, CNT_W: saturating count of debounced vehicle arrivals.
- fault, output, 1: sticky stuck-loop flag.

Behaviour:
- Reset: rst is sampled on clk; all state is cleared.
  - car_req=0, car_count=0, fault=0.
  - det=0, synchronizer flops=0, all counters=0, FSM=IDLE.
  - Reset asserted mid-operation aborts any request immediately; car_req is 0 on the cycle after rst is sampled high.
- Synchronizer: 2-flop synchronizer on loop_raw produces `s`.
- Debounce:
  - The stable counter resets whenever `s` equals `det`; it increments when `s` differs from `det`.
  - When the counter reaches DEB_CYCLES, `det` takes the value of `s` and the counter clears.
  - A pulse shorter than DEB_CYCLES samples never changes `det`.
  - Latency: loop_raw high sampled at edge t gives `s` at t+2, `det` at t+2+DEB_CYCLES, car_req at t+3+DEB_CYCLES.
- Arrival counter: increments on each 0->1 transition of `det`; saturates at all-ones and never wraps.
- FSM states, with car_req registered from the next state:
  - IDLE (car_req=0): `det`=1 -> PENDING.
  - PENDING (car_req=1): country_light==green -> EXTEND. The gap counter loads GAP_CYCLES and the green counter clears.
  - EXTEND (car_req=1):
    - `det`=1 reloads the gap counter; otherwise it decrements.
    - The green counter increments every cycle.
    - Gap counter==0 with `det`=0 -> RELEASE.
    - Green counter==MAX_GREEN-1 -> RELEASE, regardless of `det`.
    - Country light leaving green early (external override) -> RELEASE.
  - RELEASE (car_req=0): country_light!=green -> PENDING if `det`=1 or an arrival occurred while in RELEASE; otherwise IDLE.
- Simultaneous events: the MAX_GREEN cap has priority over a gap reload in the same cycle.
- country_light values 11 and yellow are treated as not green.
- Illegal FSM encodings recover to IDLE.

Optional Feature:
- Macro: STUCK_FAULT_EN.
- Defined:
  - A counter tracks continuous `det`=1 cycles.
  - Reaching STUCK_CYCLES sets `fault`=1, which stays set until rst.
  - While fault=1, `det` is treated as 0 by the FSM and by the arrival counter. Consequence: an open request completes normally via gap expiry and no new requests are raised.
- Not defined: fault is tied to 0, the stuck counter is absent, and the FSM uses `det` directly.

Decomposition:
- Shared package `traffic_pkg`:
  - Light encoding constants RED/YELLOW/GREEN (2 bits).
  - Conditioner FSM state typedef (IDLE, PENDING, EXTEND, RELEASE).
  - These are the same light constants the controller uses.
- One natural sub-module, `sync_debounce`: synchronizer plus debounce. Parameter DEB_CYCLES; outputs `det`.

Test Plan:
- Glitch rejection: loop_raw high for 3 cycles (DEB_CYCLES=4) -> `det` stays 0, car_req stays 0, car_count=0.
- Basic request: loop_raw rises at edge 10 and stays high, country_light=red -> car_req=1 at edge 17, car_count=1, car_req holds while light is red.
- Gap release: in EXTEND, loop_raw drops so `det`=0 from edge 100 -> car_req falls after exactly GAP_CYCLES=8 cycles. Light returns to red with loop low -> FSM IDLE.
- Max-green cap: loop held high continuously, light green -> car_req drops exactly MAX_GREEN=32 cycles after EXTEND entry. Light goes red with loop still high -> car_req reasserts the next cycle.
- Counter saturation and reset: 300 clean arrivals with CNT_W=8 -> car_count=255. Assert rst mid-EXTEND -> every output is 0 on the cycle after rst is sampled high.
- With STUCK_FAULT_EN and STUCK_CYCLES=16: loop held high -> fault=1 after 16 cycles of `det`=1, and car_req falls once the gap expires. Releasing the loop leaves fault=1 until rst.
